// File: rtl/serial_paralelo.sv
// Deserializer: hunts comma alignment on a 1-bit line, locks after LOCK_BCS commas, then emits each data byte.
// Latency: strobe after the byte's LSB edge. No backpressure; valid_out is a one-cycle strobe.
module serial_paralelo #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         LOCK_BCS = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       in_serial,
  output logic [7:0] out_parallel,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_BCS);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_sr;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0] r_bc_cnt, w_bc_cnt_nxt;
  logic [7:0] r_out, w_out_nxt;
  logic       r_vld, w_vld_nxt;
  logic       r_act, w_act_nxt;
  logic [7:0] w_cand;
  logic       w_is_comma;
  logic       w_boundary;

  assign w_cand     = {r_sr[6:0], in_serial};
  assign w_is_comma = (w_cand == COMMA);
  assign w_boundary = (r_bit_cnt == 3'd7);

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
    w_bc_cnt_nxt  = r_bc_cnt;
    w_out_nxt     = r_out;
    w_vld_nxt     = 1'b0;
    w_act_nxt     = r_act;
    case (r_state)
      SEARCH: begin
        w_bit_cnt_nxt = 3'd0;
        if (w_is_comma) begin
          w_bc_cnt_nxt = 4'd1;
          if (LOCK_CNT == 4'd1) begin
            w_state_nxt = ACTIVE;
            w_act_nxt   = 1'b1;
          end else begin
            w_state_nxt = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            if (r_bc_cnt != 4'hF) w_bc_cnt_nxt = r_bc_cnt + 4'd1;
            if (r_bc_cnt + 4'd1 == LOCK_CNT) begin
              w_state_nxt = ACTIVE;
              w_act_nxt   = 1'b1;
            end
          end else begin
            // Misaligned byte: drop it and restart the sliding hunt.
            w_state_nxt  = SEARCH;
            w_bc_cnt_nxt = 4'd0;
          end
        end
      end
      ACTIVE: begin
        if (w_boundary && !w_is_comma) begin
          w_out_nxt = w_cand;
          w_vld_nxt = 1'b1;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      r_state   <= SEARCH;
      r_sr      <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_bc_cnt  <= 4'd0;
      r_out     <= 8'h00;
      r_vld     <= 1'b0;
      r_act     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_cand;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bc_cnt  <= w_bc_cnt_nxt;
      r_out     <= w_out_nxt;
      r_vld     <= w_vld_nxt;
      r_act     <= w_act_nxt;
    end
  end

  assign out_parallel = r_out;
  assign valid_out    = r_vld;
  assign active       = r_act;

endmodule

// File: tb/tb_serial_paralelo.sv
// Bench for serial_paralelo: directed scenarios plus randomized traffic against a bit-index based model.
module tb_serial_paralelo;

  localparam logic [7:0] BC   = 8'hBC;
  localparam int         LOCK = 4;

  logic       clk_32f = 1'b0;
  logic       reset = 1'b0;
  logic       in_serial = 1'b0;
  logic [7:0] out_parallel;
  logic       valid_out;
  logic       active;

  serial_paralelo #(.COMMA(BC), .LOCK_BCS(LOCK)) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .in_serial   (in_serial),
    .out_parallel(out_parallel),
    .valid_out   (valid_out),
    .active      (active)
  );

  always #5 clk_32f = ~clk_32f;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: bits counted since reset; alignment remembered as the bit index
  // where the first comma completed, byte boundaries every 8 bits after it.
  int   m_win = 0;
  int   m_nbits = 0;
  int   m_anchor = -1;
  int   m_run = 0;
  bit   m_locked = 1'b0;
  logic       e_vld = 1'b0;
  logic [7:0] e_dat = 8'h00;

  logic [7:0] rx_q[$];
  logic [7:0] sent_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic b, input logic rst);
    cyc++;
    chk_en = 1'b1;
    e_vld  = 1'b0;
    if (!rst) begin
      m_win = 0; m_nbits = 0; m_anchor = -1; m_run = 0; m_locked = 1'b0; e_dat = 8'h00;
    end else begin
      m_win = ((m_win * 2) + int'(b)) % 256;
      m_nbits++;
      if (m_anchor < 0) begin
        if (m_win == int'(BC)) begin
          m_anchor = m_nbits;
          m_run = 1;
          if (m_run >= LOCK) m_locked = 1'b1;
        end
      end else if ((m_nbits - m_anchor) % 8 == 0) begin
        if (m_locked) begin
          if (m_win != int'(BC)) begin
            e_vld = 1'b1;
            e_dat = 8'(m_win);
          end
        end else if (m_win == int'(BC)) begin
          m_run++;
          if (m_run == LOCK) m_locked = 1'b1;
        end else begin
          m_anchor = -1;
          m_run = 0;
        end
      end
    end
  endtask

  task automatic drive_bit(input logic b, input logic rst);
    @(negedge clk_32f);
    in_serial = b;
    reset = rst;
    @(posedge clk_32f);
    model_step(b, rst);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive_bit(v[i], 1'b1);
  endtask

  // Transmitter model: comma while idle, data byte when valid_in is high.
  task automatic tx_slot(input logic valid_in, input logic [7:0] d);
    if (valid_in) begin
      sent_q.push_back(d);
      send_byte(d);
    end else begin
      send_byte(BC);
    end
  endtask

  task automatic check_outs(input string name, input logic act, input logic vld, input logic [7:0] dat);
    #1;
    check({name, "_active"}, 32'(active), 32'(act));
    check({name, "_valid"}, 32'(valid_out), 32'(vld));
    check({name, "_data"}, 32'(out_parallel), 32'(dat));
  endtask

  always @(negedge clk_32f) begin
    if (chk_en) begin
      check("cmp_valid", 32'(valid_out), 32'(e_vld));
      check("cmp_data", 32'(out_parallel), 32'(e_dat));
      check("cmp_active", 32'(active), 32'(m_locked));
      if (valid_out === 1'b1) rx_q.push_back(out_parallel);
    end
  end

  initial begin
    int s1, s2;
    logic [7:0] d;

    // Reset held with random line activity
    repeat (10) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    check_outs("reset", 1'b0, 1'b0, 8'h00);

    // Lock from an arbitrary bit offset
    repeat (3) drive_bit(1'($urandom_range(0, 1)), 1'b1);
    repeat (3) send_byte(BC);
    check_outs("lock_3bc", 1'b0, 1'b0, 8'h00);
    send_byte(BC);
    check_outs("lock_4bc", 1'b1, 1'b0, 8'h00);
    send_byte(8'hA5);
    check_outs("lock_a5", 1'b1, 1'b1, 8'hA5);
    s1 = cyc;
    send_byte(8'h3C);
    check_outs("lock_3c", 1'b1, 1'b1, 8'h3C);
    check("lock_gap", 32'(cyc - s1), 32'd8);

    // Idle commas while active
    send_byte(BC);
    send_byte(8'h12);
    check_outs("idle_12", 1'b1, 1'b1, 8'h12);
    s1 = cyc;
    send_byte(BC);
    send_byte(BC);
    check_outs("idle_hold", 1'b1, 1'b0, 8'h12);
    send_byte(8'h34);
    check_outs("idle_34", 1'b1, 1'b1, 8'h34);
    s2 = cyc;
    check("idle_gap", 32'(s2 - s1), 32'd24);

    // Broken comma run
    drive_bit(1'b0, 1'b0);
    send_byte(BC);
    send_byte(BC);
    send_byte(8'h55);
    check_outs("broken_55", 1'b0, 1'b0, 8'h00);
    repeat (3) send_byte(BC);
    check_outs("broken_3bc", 1'b0, 1'b0, 8'h00);
    send_byte(BC);
    check_outs("broken_lock", 1'b1, 1'b0, 8'h00);
    send_byte(8'hF0);
    check_outs("broken_f0", 1'b1, 1'b1, 8'hF0);

    // Reset mid-byte while active
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    check_outs("midrst", 1'b0, 1'b0, 8'h00);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    send_byte(8'h77);
    check_outs("midrst_77", 1'b0, 1'b0, 8'h00);
    repeat (3) send_byte(BC);
    check_outs("midrst_3bc", 1'b0, 1'b0, 8'h00);
    send_byte(BC);
    check_outs("midrst_lock", 1'b1, 1'b0, 8'h00);
    send_byte(8'h66);
    check_outs("midrst_66", 1'b1, 1'b1, 8'h66);

    // End-to-end with the transmitter, valid_in toggling over 01..0F
    drive_bit(1'b0, 1'b0);
    repeat (LOCK) tx_slot(1'b0, 8'h00);
    rx_q.delete();
    sent_q.delete();
    for (int k = 1; k <= 15; k++) begin
      tx_slot(1'b1, 8'(k));
      if (k % 3 != 0) tx_slot(1'b0, 8'h00);
    end
    tx_slot(1'b0, 8'h00);
    tx_slot(1'b0, 8'h00);
    check("e2e_count", 32'(rx_q.size()), 32'd15);
    for (int k = 0; k < 15 && k < rx_q.size(); k++)
      check("e2e_byte", 32'(rx_q[k]), 32'(k + 1));

    // Randomized traffic with occasional mid-stream reset
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 3)) drive_bit(1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 7)) drive_bit(1'($urandom_range(0, 1)), 1'b1);
      repeat (LOCK + $urandom_range(0, 2)) send_byte(BC);
      for (int s = 0; s < 12; s++) begin
        d = 8'($urandom);
        if (d == BC) d = 8'h00;
        if ($urandom_range(0, 15) == 0) begin
          repeat ($urandom_range(0, 7)) drive_bit(1'($urandom_range(0, 1)), 1'b1);
          drive_bit(1'($urandom_range(0, 1)), 1'b0);
        end
        tx_slot(1'($urandom_range(0, 1)), d);
      end
    end
    repeat (2) send_byte(BC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
